// File: rtl/jtkicker_palmix.sv
// Two-layer (obj/scr) priority mixer feeding three colour PROMs through a 3-stage
// pxl_cen pipeline. Define JTKICKER_GFXEN_EN to add the per-layer gfx_en input.
module jtkicker_palmix #(
    parameter  int PXLW = 4,
    parameter  int PALW = 3,
    parameter  int CW   = 4,
    localparam int AW   = PALW + 1 + PXLW
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            pxl_cen,
    input  logic [PALW-1:0] pal_sel,
    input  logic            obj_prio,
    input  logic [PXLW-1:0] obj_pxl,
    input  logic [PXLW-1:0] scr_pxl,
    input  logic            LHBL,
    input  logic            LVBL,
`ifdef JTKICKER_GFXEN_EN
    input  logic [1:0]      gfx_en,
`endif
    input  logic [CW-1:0]   prog_data,
    input  logic [AW-1:0]   prog_addr,
    input  logic [2:0]      prog_en,
    output logic [CW-1:0]   red,
    output logic [CW-1:0]   green,
    output logic [CW-1:0]   blue,
    output logic            LHBL_dly,
    output logic            LVBL_dly
);

    logic [CW-1:0]   prom_r [0:2**AW-1];
    logic [CW-1:0]   prom_g [0:2**AW-1];
    logic [CW-1:0]   prom_b [0:2**AW-1];

    logic [1:0]      layer_en;   // bit0 scr, bit1 obj
    logic            lhbl_last;
    logic [PALW-1:0] pal_lat;
    logic [PXLW-1:0] obj_eff, scr_eff;
    logic            obj_win;
    logic [AW-1:0]   addr_nx, addr_r;
    logic [CW-1:0]   rd_r, rd_g, rd_b;
    logic [1:0]      blank1, blank2;   // {LHBL, LVBL} after stages 1 and 2

`ifdef JTKICKER_GFXEN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer_en <= 2'b11;
        end else if (pxl_cen) begin
            layer_en <= gfx_en;
        end
    end
`else
    assign layer_en = 2'b11;
`endif

    // A disabled layer looks fully transparent to the priority logic.
    always_comb begin
        obj_eff = layer_en[1] ? obj_pxl : '0;
        scr_eff = layer_en[0] ? scr_pxl : '0;
        obj_win = (obj_eff != '0) && (!obj_prio || scr_eff == '0);
        addr_nx = {pal_lat, ~obj_win, obj_win ? obj_eff : scr_eff};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lhbl_last <= 1'b0;
            pal_lat   <= '0;
            addr_r    <= '0;
            blank1    <= 2'b00;
            rd_r      <= '0;
            rd_g      <= '0;
            rd_b      <= '0;
            blank2    <= 2'b00;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            LHBL_dly  <= 1'b0;
            LVBL_dly  <= 1'b0;
        end else if (pxl_cen) begin
            lhbl_last <= LHBL;
            // Bank only moves at the start of horizontal blank or during vblank.
            if ((lhbl_last && !LHBL) || !LVBL) begin
                pal_lat <= pal_sel;
            end
            addr_r   <= addr_nx;
            blank1   <= {LHBL, LVBL};
            rd_r     <= prom_r[addr_r];
            rd_g     <= prom_g[addr_r];
            rd_b     <= prom_b[addr_r];
            blank2   <= blank1;
            red      <= (&blank2) ? rd_r : '0;
            green    <= (&blank2) ? rd_g : '0;
            blue     <= (&blank2) ? rd_b : '0;
            LHBL_dly <= blank2[1];
            LVBL_dly <= blank2[0];
        end
    end

    // PROM contents have no reset so they survive rst; a same-cycle read sees old data.
    always_ff @(posedge clk) begin
        if (prog_en[0]) prom_r[prog_addr] <= prog_data;
        if (prog_en[1]) prom_g[prog_addr] <= prog_data;
        if (prog_en[2]) prom_b[prog_addr] <= prog_data;
    end

endmodule
